// File: rtl/rr_penc_pkg.sv
// Shared types, mode constants and helpers for the round-robin priority encoder.
// Optional feature macro: RR_PENC_POPCOUNT_EN (popcount helper used only then).
package rr_penc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // out_valid doubles as the state bit of the output register
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Index width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Number of set bits; requests are zero-extended to 64 bits
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            c += {31'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/penc_scan.sv
// Combinational request scan: MSB-first in fixed mode, rotating from a
// start index in round-robin mode.
module penc_scan
    import rr_penc_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    input  logic             mode,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic [IDX_W-1:0] pos;
    logic             found;

    // Winner search; wrap is an explicit compare so non-power-of-two N works
    always_comb begin
        idx   = '0;
        any   = |req;
        pos   = start;
        found = 1'b0;
        if (mode == MODE_FIXED) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!found && req[pos]) begin
                    idx   = pos;
                    found = 1'b1;
                end
                pos = (pos == LAST) ? '0 : pos + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered N-bit priority encoder with fixed / round-robin modes and a
// one-deep valid/ready output stage. Optional macro: RR_PENC_POPCOUNT_EN.
module rr_priority_encoder
    import rr_penc_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     req,
    input  logic             rr_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
`ifdef RR_PENC_POPCOUNT_EN
    output logic [$clog2(N+1)-1:0] out_count,
`endif
    output logic             out_zero
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    logic             any;
    logic             capture;

    // A capture requested while reset is high is dropped
    assign capture = in_valid && in_ready && !reset;

    penc_scan #(.N(N)) u_scan (
        .req   (req),
        .start (ptr),
        .mode  (rr_mode),
        .idx   (win),
        .any   (any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Next state: fill on capture, drain on accept without refill
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (capture) state_d = FULL;
            FULL:  if (out_ready && !capture) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Handshake outputs; ready is forced high while reset is asserted
    always_comb begin
        out_valid = (state_q == FULL);
        in_ready  = reset || (state_q == EMPTY) || out_ready;
    end

    // Result register and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            out_idx  <= '0;
            out_zero <= 1'b1;
            ptr      <= '0;
        end else if (capture) begin
            out_idx  <= any ? win : '0;
            out_zero <= !any;
            if (rr_mode == MODE_RR && any) begin
                ptr <= (win == LAST) ? '0 : win + IDX_W'(1);
            end
        end
    end

`ifdef RR_PENC_POPCOUNT_EN
    // Set-bit count of the captured request, held with the index
    always_ff @(posedge clk) begin
        if (reset) begin
            out_count <= '0;
        end else if (capture) begin
            out_count <= ($clog2(N+1))'(popcount(64'(req)));
        end
    end
`endif

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Scoreboard bench for rr_priority_encoder: an N=4 and an N=5 instance,
// directed vectors with hand-computed expected results.
module tb_rr_priority_encoder;

    typedef struct packed {
        logic [2:0] idx;
        logic       zero;
        logic [2:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_rr_mode;
    logic       a_out_valid, a_out_ready, a_out_zero;
    logic [3:0] a_req;
    logic [1:0] a_out_idx;
    logic [2:0] a_out_count;

    logic       b_in_valid, b_in_ready, b_rr_mode;
    logic       b_out_valid, b_out_ready, b_out_zero;
    logic [4:0] b_req;
    logic [2:0] b_out_idx;
    logic [2:0] b_out_count;

    int   checks = 0;
    int   failures = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    rr_priority_encoder #(.N(4)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .req       (a_req),
        .rr_mode   (a_rr_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_idx   (a_out_idx),
`ifdef RR_PENC_POPCOUNT_EN
        .out_count (a_out_count),
`endif
        .out_zero  (a_out_zero)
    );

    rr_priority_encoder #(.N(5)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .req       (b_req),
        .rr_mode   (b_rr_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_idx   (b_out_idx),
`ifdef RR_PENC_POPCOUNT_EN
        .out_count (b_out_count),
`endif
        .out_zero  (b_out_zero)
    );

`ifndef RR_PENC_POPCOUNT_EN
    assign a_out_count = '0;
    assign b_out_count = '0;
`endif

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor for the N=4 instance: compare on every handshake
    always @(negedge clk) begin
        if (!reset && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected: got idx %0d expected no result", a_out_idx);
            end else begin
                ea = qa.pop_front();
                check("a_idx", int'(a_out_idx), int'(ea.idx));
                check("a_zero", int'(a_out_zero), int'(ea.zero));
`ifdef RR_PENC_POPCOUNT_EN
                check("a_count", int'(a_out_count), int'(ea.cnt));
`endif
            end
        end
    end

    // Monitor for the N=5 instance
    always @(negedge clk) begin
        if (!reset && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected: got idx %0d expected no result", b_out_idx);
            end else begin
                eb = qb.pop_front();
                check("b_idx", int'(b_out_idx), int'(eb.idx));
                check("b_zero", int'(b_out_zero), int'(eb.zero));
`ifdef RR_PENC_POPCOUNT_EN
                check("b_count", int'(b_out_count), int'(eb.cnt));
`endif
            end
        end
    end

    task automatic send_a(input logic [3:0] r, input logic m,
                          input int ei, input int ez, input int ec);
        exp_t e;
        bit   ok;
        int   n;
        n = 0;
        e.idx  = 3'(ei);
        e.zero = 1'(ez);
        e.cnt  = 3'(ec);
        a_req = r;
        a_rr_mode = m;
        a_in_valid = 1'b1;
        qa.push_back(e);
        do begin
            @(negedge clk);
            ok = a_in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL a_send_timeout: got in_ready 0 expected 1");
        end
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [4:0] r, input logic m,
                          input int ei, input int ez, input int ec);
        exp_t e;
        bit   ok;
        int   n;
        n = 0;
        e.idx  = 3'(ei);
        e.zero = 1'(ez);
        e.cnt  = 3'(ec);
        b_req = r;
        b_rr_mode = m;
        b_in_valid = 1'b1;
        qb.push_back(e);
        do begin
            @(negedge clk);
            ok = b_in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL b_send_timeout: got in_ready 0 expected 1");
        end
        b_in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, qa.size() + qb.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        a_in_valid = 1'b0; a_req = '0; a_rr_mode = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_req = '0; b_rr_mode = 1'b0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(a_out_valid), 0);
        check("rst_idx", int'(a_out_idx), 0);
        check("rst_zero", int'(a_out_zero), 1);
        check("rst_in_ready", int'(a_in_ready), 1);
`ifdef RR_PENC_POPCOUNT_EN
        check("rst_count", int'(a_out_count), 0);
`endif
        reset = 1'b0;

        // Fixed mode, back to back
        send_a(4'b0001, 1'b0, 0, 0, 1);
        check("latency_valid", int'(a_out_valid), 1);
        send_a(4'b0110, 1'b0, 2, 0, 2);
        send_a(4'b1011, 1'b0, 3, 0, 3);
        send_a(4'b0000, 1'b0, 0, 1, 0);
        drain("drain_fixed");

        // Round robin with all requests set
        for (int i = 0; i < 5; i++) begin
            send_a(4'b1111, 1'b1, i % 4, 0, 4);
        end
        drain("drain_rr_full");

        // ptr=2 after winner 1; wrap search; zero keeps ptr
        send_a(4'b0010, 1'b1, 1, 0, 1);
        send_a(4'b0011, 1'b1, 0, 0, 2);
        send_a(4'b0000, 1'b1, 0, 1, 0);
        send_a(4'b1111, 1'b1, 1, 0, 4);
        drain("drain_rr_ptr");

        // Backpressure with a waiting request
        a_out_ready = 1'b0;
        send_a(4'b0100, 1'b0, 2, 0, 1);
        a_req = 4'b1000;
        a_rr_mode = 1'b0;
        a_in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", int'(a_in_ready), 0);
            check("stall_idx", int'(a_out_idx), 2);
            check("stall_valid", int'(a_out_valid), 1);
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        send_a(4'b1000, 1'b0, 3, 0, 1);
        drain("drain_stall");

        // Reset with a pending RR result and ptr=3
        a_out_ready = 1'b0;
        send_a(4'b0100, 1'b1, 2, 0, 1);
        reset = 1'b1;
        a_req = 4'b1111;
        a_rr_mode = 1'b1;
        a_in_valid = 1'b1;
        @(negedge clk);
        check("reset_in_ready", int'(a_in_ready), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        a_in_valid = 1'b0;
        qa.delete();
        check("post_rst_valid", int'(a_out_valid), 0);
        check("post_rst_zero", int'(a_out_zero), 1);
        check("post_rst_idx", int'(a_out_idx), 0);
        a_out_ready = 1'b1;
        send_a(4'b1111, 1'b1, 0, 0, 4);
        drain("drain_reset");

        // N=5: non-power-of-two wrap
        send_b(5'b10110, 1'b1, 1, 0, 3);
        send_b(5'b10000, 1'b1, 4, 0, 1);
        send_b(5'b10001, 1'b1, 0, 0, 2);
        drain("drain_n5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_priority_encoder.md
Name: rr_priority_encoder

Overview:
- Parametrised, registered successor to the 4-to-2 priority encoder.
- Encodes an N-bit request vector into an index plus a zero flag.
- Two modes, selectable at run time: fixed priority (MSB highest) or round-robin (rotating pointer).
- Result is held in a one-deep output register with a valid/ready handshake, so the block can feed a stalling consumer such as a shared decoder or display mux.

Parameters:
- N, 4, number of request lines; N >= 2.
- IDX_W, $clog2(N), width of the index output; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  req and mode are presented this cycle.
- in_ready  out  1  block can capture this cycle.
- req  in  N  request vector.
- rr_mode  in  1  0 = fixed priority (bit N-1 highest); 1 = round-robin.
- out_valid  out  1  out_idx and out_zero hold a result.
- out_ready  in  1  consumer accepts the result.
- out_idx  out  IDX_W  index of the winning request.
- out_zero  out  1  captured req was all zeros.

Behaviour:
- Reset values: out_valid=0, out_idx=0, out_zero=1, internal pointer ptr=0. in_ready is combinational and equals 1 during reset.
- in_ready = !out_valid || out_ready. Capture happens when in_valid && in_ready.
- Latency: result is valid the cycle after capture. Back-to-back captures give one result per cycle when out_ready=1.
- States (out_valid is the state bit):
  - EMPTY to FULL on capture.
  - FULL to EMPTY on out_ready with no capture.
  - FULL to FULL on simultaneous accept + capture; the register is overwritten with the new result.
  - FULL holds all outputs stable while out_ready=0. in_valid is ignored in that case.
- Fixed mode: out_idx = highest set bit index. For N=4 this matches the truth table 0001->0, 001x->1, 01xx->2, 1xxx->3.
- Round-robin mode:
  - Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N).
  - The first set bit wins.
  - On capture, ptr <= (winner+1) mod N. Wrap: winner=N-1 gives ptr=0.
- Pointer behaviour by case:
  - Fixed-mode captures leave ptr unchanged.
  - Mode changes take effect at the next capture. The held result is unaffected.
- Zero request: out_zero=1, out_idx=0 (never X), ptr unchanged. It is still a valid result and needs a handshake.
- Reset mid-operation: a pending result is discarded and ptr returns to 0. A capture requested in the reset cycle is dropped.
- All index arithmetic is IDX_W bits. For N not a power of two, wrap is an explicit compare against N-1, not natural overflow.

Optional Feature:
- Macro: RR_PENC_POPCOUNT_EN.
- When defined:
  - Adds output port out_count, width $clog2(N+1).
  - out_count is registered alongside out_idx and holds the number of set bits in the captured req.
  - Reset value is 0; it holds while stalled.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package rr_penc_pkg holds:
  - mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - function clog2_min1 (returns at least 1);
  - popcount function, used only under the macro.
- One combinational sub-module, penc_scan:
  - takes req, start index and direction-free mode;
  - returns winner index and any-set flag;
  - fixed mode is implemented as an MSB-first scan with start ignored.
- The top module owns the pointer, output register and handshake.

Test Plan (N=4 unless stated):
- Fixed mode, out_ready=1; req 0001, 0110, 1011, 0000 on consecutive cycles -> out_idx 0, 2, 3, 0, with out_zero 0, 0, 0, 1, each one cycle after capture.
- RR mode; req=1111 held for 5 captures from reset -> out_idx 0, 1, 2, 3, 0; ptr wraps after index 3.
- RR mode, ptr=2 (after winner 1); req=0011 -> out_idx 0, ptr becomes 1. Then req=0000 -> out_zero=1 and ptr stays 1.
- Backpressure: capture req=0100, hold out_ready=0 for 3 cycles while in_valid=1 with req=1000 -> in_ready=0 and out_idx stays 2. Raise out_ready -> accept and capture in the same cycle; next cycle out_idx=3.
- Reset asserted while out_valid=1 in RR mode with ptr=3 -> next cycle out_valid=0, out_zero=1, and the next RR capture with req=1111 yields 0.
- N=5 with RR_PENC_POPCOUNT_EN defined; req=10110 -> out_idx=1 (from ptr 0), out_count=3. A follow-up capture of req=10000 -> out_idx=4, then ptr wraps to 0.
